// File: rtl/prf_pkg.sv
// ----------------------------------------------------------------------------
// prf_pkg -- shared definitions for the parametrised register file.
//
// Contents:
//   FS_*           FunSel operation codes applied to every enabled register
//   sweep_state_t  two-state encoding of the sweep-clear sequencer
// ----------------------------------------------------------------------------
package prf_pkg;

    localparam logic [2:0] FS_CLR  = 3'b000;  // clear to zero
    localparam logic [2:0] FS_LOAD = 3'b001;  // load I
    localparam logic [2:0] FS_INC  = 3'b010;  // increment, modulo 2^DATA_W
    localparam logic [2:0] FS_DEC  = 3'b011;  // decrement, modulo 2^DATA_W
    localparam logic [2:0] FS_SHL  = 3'b100;  // logical shift left by 1
    localparam logic [2:0] FS_SHR  = 3'b101;  // logical shift right by 1
    localparam logic [2:0] FS_ROL  = 3'b110;  // rotate left by 1
    localparam logic [2:0] FS_HOLD = 3'b111;  // keep current value

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SWEEP = 1'b1
    } sweep_state_t;

endpackage : prf_pkg

// File: rtl/prf_cell.sv
// ----------------------------------------------------------------------------
// prf_cell -- one DATA_W-bit register with the shared FunSel datapath.
//
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset, clears the register
//   en       active-high write enable (already gated against the sweep)
//   clr      synchronous clear from the sweep sequencer, overrides en
//   fun_sel  operation applied when en is high
//   d        load data
//   q        current register contents
//   wrap     high when this edge would wrap the register on inc/dec
// ----------------------------------------------------------------------------
module prf_cell
    import prf_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              clr,
    input  logic [2:0]        fun_sel,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q,
    output logic              wrap
);

    logic [DATA_W-1:0] q_next;

    always_comb begin
        // NOTE: q_next gets a default before the case so no path leaves it
        // unassigned; otherwise synthesis infers a latch.
        q_next = q;
        case (fun_sel)
            FS_CLR:  q_next = '0;
            FS_LOAD: q_next = d;
            FS_INC:  q_next = q + DATA_W'(1);
            FS_DEC:  q_next = q - DATA_W'(1);
            FS_SHL:  q_next = {q[DATA_W-2:0], 1'b0};
            FS_SHR:  q_next = {1'b0, q[DATA_W-1:1]};
            FS_ROL:  q_next = {q[DATA_W-2:0], q[DATA_W-1]};
            FS_HOLD: q_next = q;
            default: q_next = q;
        endcase
    end

    // Wrap is predicted from the current value so the top can register a
    // single pulse that lines up with the edge that performs the wrap.
    assign wrap = en && (((fun_sel == FS_INC) && (q == '1)) ||
                         ((fun_sel == FS_DEC) && (q == '0)));

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of process ordering.
        if (!rst_n) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= q_next;
        end
    end

endmodule : prf_cell

// File: rtl/param_register_file.sv
// ----------------------------------------------------------------------------
// param_register_file -- NUM_REGS x DATA_W general/scratch register file.
//
// Every register whose active-low enable is asserted applies the shared
// FunSel operation at the rising edge. A one-cycle SweepReq starts a
// sequencer that clears one register per cycle (index 0 upward) while Busy is
// high; during the sweep all FunSel/RegEn_n writes and further requests are
// ignored. Two combinational read ports select any register; an out-of-range
// index reads 0.
//
// Ports:
//   Clock     rising-edge clock
//   Reset     asynchronous active-low reset
//   FunSel    operation for every enabled register
//   RegEn_n   per-register enable, active-low
//   I         load data
//   OutASel   read port A index
//   OutBSel   read port B index
//   SweepReq  one-cycle sweep-clear request
//   OutA      contents of register OutASel
//   OutB      contents of register OutBSel
//   Busy      high while the sweep runs (exactly NUM_REGS cycles)
//   Wrap      one-cycle pulse after an inc/dec that wrapped any register
//
// Build option:
//   PRF_BYPASS_EN  when defined, a read port whose register is being loaded
//                  this cycle (FunSel = load, enabled, not Busy) returns I.
// ----------------------------------------------------------------------------
module param_register_file
    import prf_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 8,
    parameter int SEL_W    = $clog2(NUM_REGS)
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic [2:0]          FunSel,
    input  logic [NUM_REGS-1:0] RegEn_n,
    input  logic [DATA_W-1:0]   I,
    input  logic [SEL_W-1:0]    OutASel,
    input  logic [SEL_W-1:0]    OutBSel,
    input  logic                SweepReq,
    output logic [DATA_W-1:0]   OutA,
    output logic [DATA_W-1:0]   OutB,
    output logic                Busy,
    output logic                Wrap
);

    sweep_state_t      state_q, state_d;
    logic [SEL_W-1:0]  idx_q, idx_d;
    logic              busy;

    logic [DATA_W-1:0]   reg_q [NUM_REGS];
    logic [NUM_REGS-1:0] wrap_vec;
    logic [NUM_REGS-1:0] bypass_hit;
    logic                wrap_q;

    assign busy = (state_q == ST_SWEEP);

    // ---------------------------------------------------------------- cells
    for (genvar k = 0; k < NUM_REGS; k++) begin : g_cell
        prf_cell #(
            .DATA_W (DATA_W)
        ) u_cell (
            .clk     (Clock),
            .rst_n   (Reset),
            .en      (!RegEn_n[k] && !busy),
            .clr     (busy && (idx_q == SEL_W'(k))),
            .fun_sel (FunSel),
            .d       (I),
            .q       (reg_q[k]),
            .wrap    (wrap_vec[k])
        );
    end

    // --------------------------------------------------------- sweep FSM
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            ST_IDLE: begin
                if (SweepReq) begin
                    state_d = ST_SWEEP;
                    idx_d   = '0;
                end
            end
            ST_SWEEP: begin
                // The last register is cleared on the same edge that drops
                // Busy, so Busy spans exactly NUM_REGS cycles.
                if (idx_q == SEL_W'(NUM_REGS - 1)) begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + SEL_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // ----------------------------------------------------------- wrap pulse
    // Cell enables are already gated by busy, so no wrap can be flagged
    // while the sweep runs.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            wrap_q <= 1'b0;
        end else begin
            wrap_q <= |wrap_vec;
        end
    end

    // ------------------------------------------------------------ read ports
`ifdef PRF_BYPASS_EN
    assign bypass_hit = ~RegEn_n & {NUM_REGS{!busy && (FunSel == FS_LOAD)}};
`else
    assign bypass_hit = '0;
`endif

    // Indices without a matching register (non power-of-two NUM_REGS) fall
    // through to the zero default.
    always_comb begin
        OutA = '0;
        OutB = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (OutASel == SEL_W'(k)) begin
                OutA = bypass_hit[k] ? I : reg_q[k];
            end
            if (OutBSel == SEL_W'(k)) begin
                OutB = bypass_hit[k] ? I : reg_q[k];
            end
        end
    end

    assign Busy = busy;
    assign Wrap = wrap_q;

endmodule : param_register_file

// File: tb/tb_param_register_file.sv
// ----------------------------------------------------------------------------
// tb_param_register_file -- directed self-checking bench for
// param_register_file at its default size (8 x 16 bits).
// ----------------------------------------------------------------------------
module tb_param_register_file;

    localparam int DW = 16;
    localparam int NR = 8;
    localparam int SW = 3;

    localparam logic [2:0] F_CLR  = 3'b000;
    localparam logic [2:0] F_LOAD = 3'b001;
    localparam logic [2:0] F_INC  = 3'b010;
    localparam logic [2:0] F_DEC  = 3'b011;
    localparam logic [2:0] F_SHL  = 3'b100;
    localparam logic [2:0] F_SHR  = 3'b101;
    localparam logic [2:0] F_ROL  = 3'b110;
    localparam logic [2:0] F_HOLD = 3'b111;

    logic          Clock;
    logic          Reset;
    logic [2:0]    FunSel;
    logic [NR-1:0] RegEn_n;
    logic [DW-1:0] I;
    logic [SW-1:0] OutASel;
    logic [SW-1:0] OutBSel;
    logic          SweepReq;
    logic [DW-1:0] OutA;
    logic [DW-1:0] OutB;
    logic          Busy;
    logic          Wrap;

    int checks = 0;
    int errors = 0;

    param_register_file #(
        .DATA_W   (DW),
        .NUM_REGS (NR)
    ) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .FunSel   (FunSel),
        .RegEn_n  (RegEn_n),
        .I        (I),
        .OutASel  (OutASel),
        .OutBSel  (OutBSel),
        .SweepReq (SweepReq),
        .OutA     (OutA),
        .OutB     (OutB),
        .Busy     (Busy),
        .Wrap     (Wrap)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [DW-1:0] obs,
                         input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; outputs are sampled 1 time unit later.
    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic idle_inputs();
        FunSel   = F_HOLD;
        RegEn_n  = '1;
        SweepReq = 1'b0;
    endtask

    task automatic write_one(input int k, input logic [2:0] fs,
                             input logic [DW-1:0] d);
        RegEn_n = ~(NR'(1) << k);
        FunSel  = fs;
        I       = d;
        tick();
        idle_inputs();
    endtask

    task automatic read_reg(input int k, input string tag,
                            input logic [DW-1:0] exp);
        OutASel = SW'(k);
        #1;
        check(tag, OutA, exp);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        Reset   = 1'b0;
        I       = '0;
        OutASel = '0;
        OutBSel = '0;
        idle_inputs();
        #12;
        Reset = 1'b1;
        #1;

        // ---- reset state
        for (int k = 0; k < NR; k++) read_reg(k, "reset_read", 16'h0000);
        check("reset_busy", 16'(Busy), 16'h0);
        check("reset_wrap", 16'(Wrap), 16'h0);

        // ---- random loads, then a wrap, then async reset mid-cycle
        for (int k = 0; k < NR; k++) write_one(k, F_LOAD, 16'($urandom_range(1, 16'hFFFE)));
        write_one(0, F_LOAD, 16'hFFFF);
        write_one(0, F_INC, 16'h0000);
        check("pre_reset_wrap", 16'(Wrap), 16'h1);
        #2;
        Reset = 1'b0;
        #1;
        check("async_busy", 16'(Busy), 16'h0);
        check("async_wrap", 16'(Wrap), 16'h0);
        for (int k = 0; k < NR; k++) begin
            OutASel = SW'(k);
            OutBSel = SW'(NR - 1 - k);
            #1;
            check("async_outa", OutA, 16'h0000);
            check("async_outb", OutB, 16'h0000);
        end
        tick();
        #2;
        Reset = 1'b1;
        tick();

        // ---- load and read through both ports
        RegEn_n = 8'b1111_1011;
        FunSel  = F_LOAD;
        I       = 16'hBEEF;
        tick();
        idle_inputs();
        OutASel = 3'd2;
        OutBSel = 3'd2;
        #1;
        check("load_outa", OutA, 16'hBEEF);
        check("load_outb", OutB, 16'hBEEF);
        for (int k = 0; k < NR; k++) if (k != 2) read_reg(k, "load_others", 16'h0000);

        // ---- increment / decrement wrap
        write_one(0, F_LOAD, 16'hFFFF);
        check("no_wrap_on_load", 16'(Wrap), 16'h0);
        write_one(0, F_INC, 16'h0000);
        read_reg(0, "inc_wrap_val", 16'h0000);
        check("inc_wrap_pulse", 16'(Wrap), 16'h1);
        tick();
        check("wrap_one_cycle", 16'(Wrap), 16'h0);
        write_one(0, F_DEC, 16'h0000);
        read_reg(0, "dec_wrap_val", 16'hFFFF);
        check("dec_wrap_pulse", 16'(Wrap), 16'h1);
        write_one(0, F_LOAD, 16'h0005);
        write_one(0, F_INC, 16'h0000);
        read_reg(0, "inc_val", 16'h0006);
        check("inc_no_wrap", 16'(Wrap), 16'h0);
        write_one(0, F_DEC, 16'h0000);
        read_reg(0, "dec_val", 16'h0005);

        // ---- shifts, rotate, clear, enabled hold
        write_one(1, F_LOAD, 16'h8001);
        write_one(1, F_ROL, 16'h0000);
        read_reg(1, "rol", 16'h0003);
        write_one(1, F_SHR, 16'h0000);
        read_reg(1, "shr", 16'h0001);
        write_one(1, F_LOAD, 16'h8001);
        write_one(1, F_SHL, 16'h0000);
        read_reg(1, "shl", 16'h0002);
        write_one(1, F_HOLD, 16'h7777);
        read_reg(1, "hold_enabled", 16'h0002);
        write_one(1, F_CLR, 16'h7777);
        read_reg(1, "clr", 16'h0000);
        read_reg(2, "neighbour_kept", 16'hBEEF);

        // ---- sweep-clear
        for (int k = 0; k < NR; k++) write_one(k, F_LOAD, 16'(16'h1111 * (k + 1)));
        check("busy_before_req", 16'(Busy), 16'h0);
        SweepReq = 1'b1;
        tick();
        FunSel  = F_LOAD;
        RegEn_n = '0;
        I       = 16'hABCD;
        for (int c = 0; c < NR; c++) begin
            check("sweep_busy", 16'(Busy), 16'h1);
            check("sweep_wrap", 16'(Wrap), 16'h0);
            for (int j = 0; j < NR; j++)
                read_reg(j, "sweep_reg", (j < c) ? 16'h0000 : 16'(16'h1111 * (j + 1)));
            tick();
        end
        idle_inputs();
        check("sweep_done_busy", 16'(Busy), 16'h0);
        for (int j = 0; j < NR; j++) read_reg(j, "sweep_done_reg", 16'h0000);
        tick();
        check("no_restart", 16'(Busy), 16'h0);

        // ---- reset during the sweep at index 3
        RegEn_n = '0;
        FunSel  = F_LOAD;
        I       = 16'h5A5A;
        tick();
        idle_inputs();
        SweepReq = 1'b1;
        tick();
        SweepReq = 1'b0;
        tick();
        tick();
        tick();
        check("mid_sweep_busy", 16'(Busy), 16'h1);
        read_reg(2, "mid_sweep_reg2", 16'h0000);
        read_reg(3, "mid_sweep_reg3", 16'h5A5A);
        Reset = 1'b0;
        #1;
        check("abort_busy", 16'(Busy), 16'h0);
        for (int j = 0; j < NR; j++) read_reg(j, "abort_reg", 16'h0000);
        Reset = 1'b1;
        tick();
        check("abort_idle", 16'(Busy), 16'h0);
        write_one(4, F_LOAD, 16'h0042);
        read_reg(4, "post_abort_load", 16'h0042);

        // ---- write-through visibility of a load
        OutASel = 3'd5;
        RegEn_n = 8'b1101_1111;
        FunSel  = F_LOAD;
        I       = 16'h1234;
        #1;
`ifdef PRF_BYPASS_EN
        check("bypass_same_cycle", OutA, 16'h1234);
`else
        check("no_bypass_same_cycle", OutA, 16'h0000);
`endif
        tick();
        idle_inputs();
        read_reg(5, "load_visible_after_edge", 16'h1234);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_param_register_file

// File: doc/param_register_file.md
Name: param_register_file

Overview:
Parametrised general/scratch register file for the datapath, generalising the fixed 8 x 16-bit bank to NUM_REGS x DATA_W. Every register applies a shared FunSel operation when its active-low enable is asserted. Adds a multi-cycle sweep-clear sequencer, a wrap pulse on increment/decrement, and two combinational read ports. Sits between the ALU/memory result bus (I) and the ALU operand muxes (OutA/OutB).

Parameters:
DATA_W, 16, register width in bits (>=2)
NUM_REGS, 8, number of registers (>=2); index 0..NUM_REGS-1
SEL_W, $clog2(NUM_REGS), read/sweep index width (derived; not overridden)

Ports:
Clock  input  1  rising-edge clock
Reset  input  1  asynchronous active-low reset
FunSel  input  3  operation applied to every enabled register
RegEn_n  input  NUM_REGS  per-register enable, active-low; bit k enables register k
I  input  DATA_W  load data
OutASel  input  SEL_W  read port A index
OutBSel  input  SEL_W  read port B index
SweepReq  input  1  one-cycle request to clear all registers sequentially
OutA  output  DATA_W  contents of register OutASel
OutB  output  DATA_W  contents of register OutBSel
Busy  output  1  high while the sweep is in progress
Wrap  output  1  registered pulse: some enabled register wrapped on inc/dec last edge

Behaviour:
- Reset low (async): all registers = 0, Busy = 0, Wrap = 0, sweep index = 0, FSM = IDLE. OutA/OutB therefore read 0.
- FunSel encoding (per enabled register, at the rising edge): 000 clear; 001 load I; 010 increment (mod 2^DATA_W); 011 decrement (mod 2^DATA_W); 100 shift left logical by 1; 101 shift right logical by 1; 110 rotate left by 1; 111 hold.
- Registers with RegEn_n[k] = 1 hold. All-ones RegEn_n is a no-op.
- Reads: OutA/OutB are combinational muxes of current register contents. Both ports may select the same register. Out-of-range index (NUM_REGS not a power of 2) reads 0.
- Wrap: asserted for exactly one cycle after an edge where at least one enabled register went 2^DATA_W-1 -> 0 on increment, or 0 -> 2^DATA_W-1 on decrement. Otherwise 0.
- Sweep FSM, states IDLE and SWEEP:
  - IDLE + SweepReq = 1: next state SWEEP, index = 0, Busy = 1 from the next cycle. FunSel/RegEn_n in the request cycle still take effect normally.
  - SWEEP: each edge clears register[index] and increments the index. After clearing register NUM_REGS-1, the FSM returns to IDLE; Busy falls in that same edge.
  - Busy therefore stays high for exactly NUM_REGS cycles.
  - While in SWEEP: FunSel/RegEn_n are ignored entirely (no writes, Wrap stays 0), SweepReq is ignored, and reads remain live.
- Reset asserted mid-sweep aborts the sweep. All registers are 0 and the FSM is IDLE.

Optional Feature:
PRF_BYPASS_EN — when defined, a read port whose selected register is enabled with FunSel = 001 (load) in the current cycle returns I combinationally (write-through). The bypass is suppressed while Busy. When not defined, reads always return stored contents; the loaded value is visible the cycle after the edge.

Decomposition:
- Package prf_pkg: FunSel localparams (FS_CLR, FS_LOAD, FS_INC, FS_DEC, FS_SHL, FS_SHR, FS_ROL, FS_HOLD) and sweep FSM state encodings.
- Sub-module prf_cell: one DATA_W register with enable, FunSel datapath, sync clear input (driven by the sweep) and wrap-detect output. Instantiate it NUM_REGS times.

Test Plan:
- Reset check: drop Reset mid-cycle after random loads -> all reads = 0x0000, Busy = 0, Wrap = 0 immediately, before any clock edge.
- Load and read: RegEn_n = 8'b1111_1011, FunSel = 001, I = 0xBEEF, edge; OutASel = 2, OutBSel = 2 -> OutA = OutB = 0xBEEF, other registers still 0.
- Wrap on increment: load reg0 = 0xFFFF, then FunSel = 010 -> reg0 = 0x0000 and Wrap = 1 for one cycle. Decrement from 0 -> 0xFFFF with Wrap = 1. Increment 0x0005 -> 0x0006 with Wrap = 0.
- Shifts: reg1 = 0x8001; ROL -> 0x0003; SHR -> 0x0001; SHL from 0x8001 -> 0x0002.
- Sweep: load all registers with 0x1111 * (k+1), pulse SweepReq -> Busy high for exactly 8 cycles, register k reads 0 from edge k+1 onward. FunSel = 001 with RegEn_n = 0 during the sweep has no effect.
- Reset mid-sweep at index 3 -> FSM IDLE, Busy = 0, all registers 0; a subsequent load works normally. With PRF_BYPASS_EN, loading reg5 = 0x1234 while OutASel = 5 -> OutA = 0x1234 in the same cycle.
